// File: rtl/camera_qsys_led_driver.sv
// LED pin driver behind the Qsys LED PIO: global PWM dimming, a full-brightness
// flash after each new request, and a one-LED-at-a-time lamp-test sweep.
module camera_qsys_led_driver #(
   parameter int NUM_LEDS      = 10,
   parameter int PWM_BITS      = 8,
   parameter int PRESCALE      = 50,
   parameter int FLASH_PERIODS = 16
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [NUM_LEDS-1:0] i_led_in,
   input  logic [PWM_BITS-1:0] i_brightness,
   input  logic                i_lamp_test,
   output logic [NUM_LEDS-1:0] o_led_out,
   output logic                o_busy
);

   localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IDX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

   localparam logic [PRESC_W-1:0]  PRESC_MAX  = PRESC_W'(PRESCALE - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(NUM_LEDS - 1);
   localparam logic [7:0]          FLASH_LOAD = 8'(FLASH_PERIODS);
   localparam logic [NUM_LEDS-1:0] LED_ONE    = NUM_LEDS'(1);

   typedef enum logic [0:0] {
      ST_NORMAL,
      ST_SWEEP
   } state_t;

   logic [PRESC_W-1:0]  r_presc;
   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic [PWM_BITS-1:0] r_bright_q;
   logic [NUM_LEDS-1:0] r_led_q;
   logic [7:0]          r_flash [NUM_LEDS];
   logic [IDX_W-1:0]    r_index;
   logic [NUM_LEDS-1:0] r_led_out;
   state_t              r_state;

   logic                w_tick;
   logic                w_period_end;
   logic                w_pwm_on;
   logic [NUM_LEDS-1:0] w_rise;
   logic [NUM_LEDS-1:0] w_flash_act;
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    w_index_nxt;
   logic [NUM_LEDS-1:0] w_led_out_nxt;

   assign w_tick       = (r_presc == PRESC_MAX);
   assign w_period_end = w_tick & (r_pwm_cnt == '1);
   assign w_pwm_on     = (r_bright_q == '1) | (r_pwm_cnt < r_bright_q);
   assign w_rise       = i_led_in & ~r_led_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_presc    <= '0;
         r_pwm_cnt  <= '0;
         r_bright_q <= '1;
         r_led_q    <= '0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
         if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
         end
         // Brightness is only adopted at a period boundary so a duty change never tears a period.
         if (w_period_end) begin
            r_bright_q <= i_brightness;
         end
         r_led_q <= i_led_in;
      end
   end

   // A new request reloads its flash even though led_q is still 0, so load outranks the clear.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
         if (i_reset) begin
            r_flash[i] <= '0;
         end else if (w_rise[i]) begin
            r_flash[i] <= FLASH_LOAD;
         end else if (!r_led_q[i]) begin
            r_flash[i] <= '0;
         end else if (w_period_end && (r_flash[i] != '0)) begin
            r_flash[i] <= r_flash[i] - 8'd1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_LEDS; i++) begin
         w_flash_act[i] = (r_flash[i] != '0);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= ST_NORMAL;
         r_index   <= '0;
         r_led_out <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_index   <= w_index_nxt;
         r_led_out <= w_led_out_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_index_nxt   = r_index;
      w_led_out_nxt = '0;
      case (r_state)
         ST_NORMAL: begin
            w_led_out_nxt = r_led_q & (w_flash_act | {NUM_LEDS{w_pwm_on}});
            if (i_lamp_test) begin
               w_state_nxt = ST_SWEEP;
               w_index_nxt = '0;
            end
         end
         ST_SWEEP: begin
            w_led_out_nxt = LED_ONE << r_index;
            if (w_period_end) begin
               if (r_index == IDX_LAST) begin
                  w_state_nxt = ST_NORMAL;
                  w_index_nxt = '0;
               end else begin
                  w_index_nxt = r_index + IDX_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = ST_NORMAL;
            w_index_nxt = '0;
         end
      endcase
   end

   assign o_led_out = r_led_out;
   assign o_busy    = (r_state == ST_SWEEP);

endmodule

// File: tb/tb_camera_qsys_led_driver.sv
// Directed bench for camera_qsys_led_driver with PRESCALE=4, PWM_BITS=4, FLASH_PERIODS=2,
// so one PWM period is 64 clk; n counts clock edges since the last reset edge.
module tb_camera_qsys_led_driver;

   logic       clk;
   logic       reset;
   logic [9:0] ledIn;
   logic [3:0] brightness;
   logic       lampTest;
   logic [9:0] ledOut;
   logic       busy;

   int checks;
   int errors;
   int n;

   camera_qsys_led_driver #(
      .NUM_LEDS      (10),
      .PWM_BITS      (4),
      .PRESCALE      (4),
      .FLASH_PERIODS (2)
   ) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_led_in     (ledIn),
      .i_brightness (brightness),
      .i_lamp_test  (lampTest),
      .o_led_out    (ledOut),
      .o_busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
      n++;
   endtask

   // Hold reset for three edges with the given inputs; n restarts at 0 on the last reset edge.
   task automatic doReset(input logic [9:0] led, input logic [3:0] bright);
      reset      = 1'b1;
      ledIn      = led;
      brightness = bright;
      lampTest   = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      n     = 0;
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      ledIn      = 10'h3FF;
      brightness = 4'hF;
      lampTest   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (ledOut !== 10'h000 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold k=%0d led_out=%h busy=%b exp led_out=000 busy=0", k, ledOut, busy);
         end
      end
      reset = 1'b0;
      n     = 0;
      step();
      checks++;
      if (ledOut !== 10'h000) begin
         errors++;
         $display("[TB] FAIL reset_latency1 led_out=%h exp=000", ledOut);
      end
      step();
      checks++;
      if (ledOut !== 10'h3FF || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_latency2 led_out=%h busy=%b exp led_out=3ff busy=0", ledOut, busy);
      end
   endtask

   task automatic test_pwm_duty();
      logic [9:0] exp;
      doReset(10'h001, 4'h4);
      for (int k = 1; k <= 192; k++) begin
         step();
         if (n < 2)         exp = 10'h000;
         else if (n <= 128) exp = 10'h001;
         else               exp = (((n - 1) / 4) % 16 < 4) ? 10'h001 : 10'h000;
         checks++;
         if (ledOut !== exp) begin
            errors++;
            $display("[TB] FAIL pwm_duty n=%0d led_out=%h exp=%h", n, ledOut, exp);
         end
      end
   endtask

   task automatic test_flash();
      logic [9:0] exp;
      doReset(10'h000, 4'h0);
      for (int k = 1; k <= 272; k++) begin
         step();
         if ((n >= 72 && n <= 192) || (n >= 264 && n <= 267)) exp = 10'h002;
         else                                                  exp = 10'h000;
         checks++;
         if (ledOut !== exp) begin
            errors++;
            $display("[TB] FAIL flash n=%0d led_out=%h exp=%h", n, ledOut, exp);
         end
         if (n == 70)  ledIn = 10'h002;
         if (n == 260) ledIn = 10'h000;
         if (n == 262) ledIn = 10'h002;
         if (n == 266) ledIn = 10'h000;
      end
   endtask

   task automatic test_brightness_change();
      logic [9:0] exp;
      doReset(10'h001, 4'h4);
      for (int k = 1; k <= 256; k++) begin
         step();
         if (n < 2)         exp = 10'h000;
         else if (n <= 128) exp = 10'h001;
         else if (n <= 192) exp = (((n - 1) / 4) % 16 < 4)  ? 10'h001 : 10'h000;
         else               exp = (((n - 1) / 4) % 16 < 12) ? 10'h001 : 10'h000;
         checks++;
         if (ledOut !== exp) begin
            errors++;
            $display("[TB] FAIL bright_change n=%0d led_out=%h exp=%h", n, ledOut, exp);
         end
         if (n == 137) brightness = 4'hC;
      end
   endtask

   task automatic test_sweep();
      logic [9:0] expLed;
      logic       expBusy;
      doReset(10'h000, 4'hF);
      for (int k = 1; k <= 650; k++) begin
         step();
         expBusy = (n >= 11 && n <= 639);
         if (n <= 11)       expLed = 10'h000;
         else if (n <= 640) expLed = 10'h001 << ((n - 1) / 64);
         else               expLed = 10'h3FF;
         checks++;
         if (ledOut !== expLed || busy !== expBusy) begin
            errors++;
            $display("[TB] FAIL sweep n=%0d led_out=%h busy=%b exp led_out=%h busy=%b",
                     n, ledOut, busy, expLed, expBusy);
         end
         if (n == 10)  lampTest = 1'b1;
         if (n == 11)  lampTest = 1'b0;
         if (n == 200) lampTest = 1'b1;
         if (n == 201) lampTest = 1'b0;
         if (n == 300) ledIn    = 10'h3FF;
      end
   endtask

   task automatic test_reset_mid_sweep();
      logic [9:0] expLed;
      logic       expBusy;
      int         total;
      doReset(10'h000, 4'hF);
      total = 0;
      for (int k = 1; k <= 420; k++) begin
         step();
         total++;
         if (total >= 11 && total <= 340) expBusy = 1'b1;
         else                             expBusy = 1'b0;
         if (total >= 12 && total <= 340) expLed = 10'h001 << ((total - 1) / 64);
         else if (total >= 347)           expLed = 10'h001;
         else                             expLed = 10'h000;
         checks++;
         if (ledOut !== expLed || busy !== expBusy) begin
            errors++;
            $display("[TB] FAIL reset_mid_sweep t=%0d led_out=%h busy=%b exp led_out=%h busy=%b",
                     total, ledOut, busy, expLed, expBusy);
         end
         if (total == 10)  lampTest = 1'b1;
         if (total == 11)  lampTest = 1'b0;
         if (total == 340) reset    = 1'b1;
         if (total == 341) reset    = 1'b0;
         if (total == 345) ledIn    = 10'h001;
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      n          = 0;
      reset      = 1'b1;
      ledIn      = 10'h000;
      brightness = 4'hF;
      lampTest   = 1'b0;
      test_reset();
      test_pwm_duty();
      test_flash();
      test_brightness_change();
      test_sweep();
      test_reset_mid_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

endmodule
